pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall and flush sequencer for the five-stage pipeline. Each cycle it drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It resolves four conditions: data-memory waits, taken redirects resolved in MEM, load-use hazards, and instruction-fetch misses. A small FSM tracks outstanding data accesses and halt draining, and a counter records stall cycles for performance debug.

## Interface
- CNT_W, 32, width of stall-cycle counter
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- exmem_dREN, exmem_dWEN  in  1 each  MEM-stage instruction reads / writes data memory
- redirect  in  1  MEM-stage taken branch, jump or JR (PC loads target)
- halt  in  1  MEM-stage instruction is HALT
- idex_dREN  in  1  EX-stage instruction is a load
- idex_rt  in  5  EX-stage load destination register
- ifid_rs, ifid_rt  in  5 each  ID-stage source registers
- ifid_uses_rt  in  1  ID-stage instruction reads rt
- pc_en  out  1  PC register update enable
- ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  latch write enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch clears; sampled at the clock edge; override wen
- halted  out  1  pipeline stopped; sticky until reset
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 before halt

## Operation
- FSM states:
  - RUN: normal issue.
  - DWAIT: data access outstanding.
  - DRAIN: halt instruction in WB.
  - HALTED: terminal state.
- Defaults: all wen=1, all flush=0, pc_en=1.
- Priority, highest first: data stall > halt > redirect > load-use > fetch miss.
- Data stall: memop = exmem_dREN|exmem_dWEN.
  - In RUN with memop & !dhit: all wen=0, pc_en=0; next state DWAIT.
  - In DWAIT with !dhit: same freeze.
  - In DWAIT with dhit: defaults apply, plus any lower-priority action; next state RUN.
  - In RUN with memop & dhit: no stall.
- Halt in RUN/DWAIT, not data-stalled:
  - ifid_flush=idex_flush=exmem_flush=1, pc_en=0, memwb_wen=1; next state DRAIN.
- DRAIN: all wen=0, pc_en=0; next state HALTED.
- HALTED: all wen=0, pc_en=0, halted=1. Exit only via nRST.
- Redirect, not data-stalled: ifid_flush=idex_flush=exmem_flush=1, pc_en=1, even if ihit=0.
- Load-use:
  - Condition: idex_dREN & idex_rt≠0 & (ifid_rs==idex_rt | (ifid_uses_rt & ifid_rt==idex_rt)).
  - Action: pc_en=0, ifid_wen=0, idex_flush=1. EX/MEM and MEM/WB advance.
- Fetch miss (!ihit, no higher condition): pc_en=0, ifid_flush=1 (bubble). Downstream latches advance.
- Counter: stall_cycles increments in every RUN/DWAIT cycle with pc_en=0 and holds at 2^CNT_W−1. It does not count in DRAIN or HALTED.

## Timing
- All outputs except halted and stall_cycles are combinational from state and inputs. There is no added latency.
- halted is registered: it rises 2 edges after the cycle in which halt was accepted in MEM.
- Reset (async): state=RUN, halted=0, stall_cycles=0. While nRST=0, outputs follow RUN decode.
- Reset mid-DWAIT or mid-DRAIN returns to RUN immediately. A pending dhit is ignored.
- dhit and redirect in the same DWAIT cycle: the access completes and the redirect flush applies in that cycle.
- Load-use and !ihit together: load-use wins. ifid holds and is not flushed.

## Structure
- cpu_types_pkg gains:
  - typedef enum logic [1:0] pctrl_state_t {RUN, DWAIT, DRAIN, HALTED}.
  - regbits_t, reused for 5-bit register fields.
- Sub-module load_use_detect: purely combinational hazard compare producing one bit. It is instantiated once.
- The FSM, priority decode and counter live in pipeline_ctrl.

## Test plan
- exmem_dREN=1, dhit held 0 for 3 cycles then 1 → all wen=0 and pc_en=0 for 3 cycles. In the 4th cycle all wen=1; state returns RUN; stall_cycles=3.
- idex_dREN=1, idex_rt=5, ifid_rs=5, ihit=1 → pc_en=0, ifid_wen=0, idex_flush=1, memwb_wen=1. Repeat with idex_rt=0 → no stall.
- redirect=1, ihit=0 → pc_en=1; ifid/idex/exmem flush=1; memwb_wen=1; stall_cycles unchanged.
- halt=1 in RUN → flushes asserted that cycle. Next cycle all wen=0. halted=1 after 2nd edge and stays 1 for 10 further cycles with toggling ihit/dhit.
- Assert nRST=0 mid-DWAIT → state RUN, halted=0, stall_cycles=0 asynchronously.
- CNT_W=4 with 20 consecutive fetch misses → stall_cycles saturates at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register field width and pipeline-controller FSM states.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Purely combinational, one hazard bit out.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_dREN,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ifid_uses_rt,
    output logic     hazard
);

    // A load into r0 never creates a dependency.
    assign hazard = idex_dREN && (idex_rt != '0) &&
                    ((ifid_rs == idex_rt) || (ifid_uses_rt && (ifid_rt == idex_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline latches and PC enable.
// Decode is combinational from state and inputs; halted and stall_cycles are registered.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             redirect,
    input  logic             halt,
    input  logic             idex_dREN,
    input  regbits_t         idex_rt,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    input  logic             ifid_uses_rt,
    output logic             pc_en,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    pctrl_state_t state, next_state;
    logic         memop;
    logic         mem_stall;
    logic         lu_hazard;
    logic         count_en;

    load_use_detect u_lud (
        .idex_dREN    (idex_dREN),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .hazard       (lu_hazard)
    );

    assign memop = exmem_dREN | exmem_dWEN;

    // Once in DWAIT the access is outstanding regardless of what MEM now shows.
    assign mem_stall = (state == DWAIT) ? !dhit
                                        : ((state == RUN) && memop && !dhit);

    always_comb begin
        next_state  = state;
        pc_en       = 1'b1;
        ifid_wen    = 1'b1;
        idex_wen    = 1'b1;
        exmem_wen   = 1'b1;
        memwb_wen   = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        case (state)
            DRAIN, HALTED: begin
                pc_en      = 1'b0;
                ifid_wen   = 1'b0;
                idex_wen   = 1'b0;
                exmem_wen  = 1'b0;
                memwb_wen  = 1'b0;
                next_state = HALTED;
            end
            default: begin
                if (mem_stall) begin
                    pc_en      = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_wen   = 1'b0;
                    exmem_wen  = 1'b0;
                    memwb_wen  = 1'b0;
                    next_state = DWAIT;
                end else begin
                    next_state = RUN;
                    if (halt) begin
                        // HALT itself still retires into MEM/WB.
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        pc_en       = 1'b0;
                        next_state  = DRAIN;
                    end else if (redirect) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (lu_hazard) begin
                        pc_en      = 1'b0;
                        ifid_wen   = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            end
        endcase
    end

    assign count_en = ((state == RUN) || (state == DWAIT)) && !pc_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= RUN;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= next_state;
            if (state == DRAIN)
                halted <= 1'b1;
            if (count_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised and directed check of pipeline_ctrl against a rule-level model.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic CLK, nRST;
    logic ihit, dhit, exmem_dREN, exmem_dWEN, redirect, halt, idex_dREN, ifid_uses_rt;
    regbits_t idex_rt, ifid_rs, ifid_rt;
    logic pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .redirect(redirect), .halt(halt), .idex_dREN(idex_dREN),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .pc_en(pc_en),
        .ifid_wen(ifid_wen), .idex_wen(idex_wen), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .halted(halted), .stall_cycles(stall_cycles)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: data access outstanding, halt progress (0 none, 1 draining, 2 stopped), counters.
    bit m_pend;
    int m_ph;
    int m_cnt;
    bit m_halted;

    always @(negedge CLK) begin
        bit       dwait, lu, e_pc;
        logic [3:0] e_wen, e_fl;
        if (!nRST) begin
            m_pend = 0; m_ph = 0; m_cnt = 0; m_halted = 0;
        end
        e_pc = 1; e_wen = 4'b1111; e_fl = 4'b0000;
        dwait = m_pend ? !dhit : ((exmem_dREN || exmem_dWEN) && !dhit);
        lu = idex_dREN && idex_rt != 0 &&
             (ifid_rs == idex_rt || (ifid_uses_rt && ifid_rt == idex_rt));
        if (m_ph != 0) begin
            e_pc = 0; e_wen = 4'b0000;
        end else if (dwait) begin
            e_pc = 0; e_wen = 4'b0000;
        end else if (halt) begin
            e_pc = 0; e_fl = 4'b1110;
        end else if (redirect) begin
            e_fl = 4'b1110;
        end else if (lu) begin
            e_pc = 0; e_wen[3] = 0; e_fl[2] = 1;
        end else if (!ihit) begin
            e_pc = 0; e_fl[3] = 1;
        end
        chk("ctrl", {23'd0, pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush},
            {23'd0, e_pc, e_wen, e_fl});
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        if (nRST) begin
            if (m_ph == 1) begin
                m_ph = 2; m_halted = 1;
            end else if (m_ph == 0) begin
                if (!e_pc && m_cnt < CMAX) m_cnt++;
                if (dwait) m_pend = 1;
                else begin
                    m_pend = 0;
                    if (halt) m_ph = 1;
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1; dhit = 0; exmem_dREN = 0; exmem_dWEN = 0; redirect = 0; halt = 0;
        idex_dREN = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
    endtask

    task automatic do_reset();
        idle();
        nRST = 0;
        next_cyc();
        next_cyc();
        nRST = 1;
    endtask

    initial begin
        idle();
        nRST = 1;
        #1 nRST = 0;
        next_cyc();
        nRST = 1;
        #2;
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_cnt", 32'(stall_cycles), 32'd0);
        chk("reset_pc_en", {31'd0, pc_en}, 32'd1);
        next_cyc();

        // Data wait of three cycles, completing on the fourth.
        do_reset();
        exmem_dREN = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("dwait_freeze", {27'd0, pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen}, 32'd0);
            next_cyc();
        end
        dhit = 1;
        #2;
        chk("dwait_done", {27'd0, pc_en, ifid_wen, idex_wen, exmem_wen, memwb_wen}, 32'h1f);
        next_cyc();
        idle();
        #2;
        chk("dwait_cnt", 32'(stall_cycles), 32'd3);
        next_cyc();

        // Load-use, then the same with a load into r0.
        idex_dREN = 1; idex_rt = 5; ifid_rs = 5;
        #2;
        chk("lu_stall", {28'd0, pc_en, ifid_wen, idex_flush, memwb_wen}, 32'b0011);
        next_cyc();
        idex_rt = 0; ifid_rs = 0;
        #2;
        chk("lu_r0", {28'd0, pc_en, ifid_wen, idex_flush, memwb_wen}, 32'b1101);
        next_cyc();

        // Redirect overrides a fetch miss and does not count.
        do_reset();
        redirect = 1; ihit = 0;
        #2;
        chk("redirect", {27'd0, pc_en, ifid_flush, idex_flush, exmem_flush, memwb_wen}, 32'h1f);
        next_cyc();
        idle();
        #2;
        chk("redirect_cnt", 32'(stall_cycles), 32'd0);
        next_cyc();

        // Halt, drain, then sticky halted.
        do_reset();
        halt = 1;
        #2;
        chk("halt_accept", {27'd0, pc_en, ifid_flush, idex_flush, exmem_flush, memwb_wen}, 32'h0f);
        next_cyc();
        halt = 0;
        #2;
        chk("drain_wen", {28'd0, ifid_wen, idex_wen, exmem_wen, memwb_wen}, 32'd0);
        chk("drain_halted", {31'd0, halted}, 32'd0);
        next_cyc();
        for (int i = 0; i < 11; i++) begin
            ihit = i[0]; dhit = ~i[0];
            #2;
            chk("halted_sticky", {31'd0, halted}, 32'd1);
            next_cyc();
        end

        // Asynchronous reset while a data access is outstanding.
        do_reset();
        exmem_dWEN = 1;
        next_cyc();
        next_cyc();
        #1;
        nRST = 0;
        #1;
        chk("arst_cnt", 32'(stall_cycles), 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        idle();
        #1;
        chk("arst_run", {31'd0, pc_en}, 32'd1);
        next_cyc();
        nRST = 1;

        // Saturation after 20 fetch misses.
        do_reset();
        ihit = 0;
        for (int i = 0; i < 20; i++) next_cyc();
        idle();
        #2;
        chk("saturate", 32'(stall_cycles), 32'd15);
        next_cyc();

        // Random traffic with occasional resets and halts.
        for (int i = 0; i < 3000; i++) begin
            nRST         = ($urandom_range(0, 149) != 0);
            ihit         = ($urandom_range(0, 3) != 0);
            dhit         = $urandom_range(0, 1);
            exmem_dREN   = ($urandom_range(0, 4) == 0);
            exmem_dWEN   = ($urandom_range(0, 5) == 0);
            redirect     = ($urandom_range(0, 5) == 0);
            halt         = ($urandom_range(0, 79) == 0);
            idex_dREN    = ($urandom_range(0, 2) == 0);
            idex_rt      = regbits_t'($urandom_range(0, 3));
            ifid_rs      = regbits_t'($urandom_range(0, 3));
            ifid_rt      = regbits_t'($urandom_range(0, 3));
            ifid_uses_rt = $urandom_range(0, 1);
            next_cyc();
        end
        nRST = 1;
        idle();
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
